bt_txd: RTL
===========

// Module: bt_txd
// PURPOSE
//  UART transmitter toward the Bluetooth module. It is the TX counterpart of the existing BT receiver.
//  Bytes are buffered in a small FIFO. Each byte is sent as 8N1 (or 8N2), LSB first.
//  Bit timing comes from the shared external baud tick generator; this block enables that generator via baud_en.
// PARAMETERS
//  DATA_BITS   8  payload bits per frame (sent LSB first)
//  STOP_BITS   1  number of stop bits; legal values are 1 or 2
//  FIFO_AW     2  FIFO address width; depth = 2**FIFO_AW = 4 bytes
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous reset, active-low
//  tx_data    in   DATA_BITS  byte to send; sampled when tx_wr=1
//  tx_wr      in   1          write strobe, one cycle per byte
//  tx_full    out  1          FIFO full; a write made while this is 1 is dropped
//  baud_tick  in   1          one-cycle pulse per bit period from the baud generator
//  baud_en    out  1          enables the baud generator; 1 for the whole time frames are being sent
//  txd        out  1          serial line; idles high
//  tx_busy    out  1          1 while the FSM is not IDLE
//  tx_done    out  1          one-cycle pulse when the last stop bit of a frame ends
// BEHAVIOUR
//  Reset (rst=0 at a clk edge):
//   - txd=1; baud_en, tx_busy, tx_done = 0.
//   - FIFO pointers and count are cleared; tx_full=0.
//   - Reset mid-frame abandons the frame. txd returns high on that same edge.
//  FIFO:
//   - tx_wr=1 and tx_full=0 pushes tx_data.
//   - tx_full is registered (count==DEPTH). A write while full is dropped, even if a pop happens in the same cycle.
//   - Push and pop in the same cycle leave count unchanged.
//   - The FSM pops only when count != 0.
//  FSM states: IDLE, START, DATA, STOP. All outputs are registered.
//   - IDLE: when the FIFO is non-empty, pop the head into shift_reg, set txd<=0 (start bit), set baud_en<=1, go to START.
//     baud_tick is ignored in IDLE.
//   - START: on baud_tick, txd<=shift_reg[0], bit_cnt<=0, go to DATA.
//   - DATA: on baud_tick:
//     - if bit_cnt==DATA_BITS-1: txd<=1, stop_cnt<=0, go to STOP;
//     - else shift right, txd<=next bit, bit_cnt+1.
//   - STOP: on baud_tick:
//     - if stop_cnt==STOP_BITS-1, pulse tx_done. Then:
//       - FIFO non-empty: pop, txd<=0, go to START. baud_en stays 1, so frames are back-to-back with no idle gap.
//       - FIFO empty: baud_en<=0, go to IDLE.
//     - else stop_cnt+1.
//  Bit timing:
//   - The generator is required to issue its first tick one full bit period after baud_en rises.
//   - Every bit therefore lasts exactly one tick interval.
//  Latency: tx_wr at edge N into an empty FIFO with the FSM in IDLE -> count=1 after N -> pop at N+1 -> txd falls after N+1.
//  Widths: bit_cnt is $clog2(DATA_BITS) bits; stop_cnt is 1 bit; FIFO count is FIFO_AW+1 bits (no wrap at full).
//  Pointers wrap modulo DEPTH.
//  tx_busy=1 from the IDLE->START transition until the STOP->IDLE transition.
// STRUCTURE
//  Shared package/header holds:
//   - FSM state encodings (TX_IDLE=2'd0, TX_START=1, TX_DATA=2, TX_STOP=3);
//   - BT_DATA_BITS=8.
//  Sub-module bt_tx_fifo:
//   - synchronous single-clock FIFO with push/pop/full/empty/count;
//   - reused by later BT command blocks.
//  The FSM and shift register live in bt_txd.
// TESTING
//  Baud tick every 16 clk in all tests. Bits are listed as txd values sampled at mid-bit.
//  1. Reset, then write 0x55 -> txd = 0,1,0,1,0,1,0,1,0,1 (start, 8 data, stop); one tx_done pulse; baud_en=0 after the stop bit.
//  2. Write 0xA3 and 0x0F on consecutive cycles -> frames 0,1,1,0,0,0,1,0,1,1 then 0,1,1,1,1,0,0,0,0,1.
//     No idle high between the frames; baud_en stays 1; two tx_done pulses.
//  3. Write 5 bytes 0x01..0x05 in 5 consecutive cycles while the FSM is busy -> tx_full=1 after the 4th buffered byte.
//     The dropped byte (0x05) is never sent; bytes 0x01..0x04 appear in order.
//  4. Pull rst low in the middle of the DATA state of 0xFF, with 2 bytes still queued ->
//     txd=1, baud_en=0, tx_busy=0 next cycle; FIFO empty; no further frames.
//  5. STOP_BITS=2, write 0x00 -> txd low for 9 bit times, then high for 2 bit times before tx_done.
//  6. Pulse baud_tick while in IDLE with the FIFO empty -> txd stays 1, baud_en stays 0, no state change.

Source files
------------

// File: rtl/bt_txd_pkg.sv
// Shared definitions for the Bluetooth UART transmit path.
// Holds the transmitter FSM state encoding and the default payload width.
// Later BT command blocks import this package as well.
package bt_txd_pkg;

    localparam int BT_DATA_BITS = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/bt_tx_fifo.sv
// Synchronous single-clock FIFO used to buffer bytes for the BT transmitter.
// Ports:
//   clk    system clock
//   rst    synchronous reset, active-low (clears pointers, count and full)
//   push   write request; ignored while full
//   wdata  data written on an accepted push
//   pop    read request; ignored while empty
//   rdata  current head of the FIFO (valid while not empty)
//   full   registered, high when count == DEPTH
//   empty  high when count == 0
//   count  number of stored entries, FIFO_AW+1 bits so it never wraps
module bt_tx_fifo
    import bt_txd_pkg::*;
#(
    parameter int WIDTH = BT_DATA_BITS,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_next;
    logic             push_ok;
    logic             pop_ok;

    // A write while full is dropped even if a pop happens in the same cycle,
    // because full reflects the registered count, not the post-pop value.
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count != '0);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Pointers wrap naturally modulo DEPTH; full is registered from the
    // next count so it is valid on the same edge the count changes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == (AW + 1)'(DEPTH));
        end
    end

    // Storage needs no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/bt_txd.sv
// UART transmitter toward the Bluetooth module (TX side of the BT receiver).
// Bytes are queued in a small FIFO and sent LSB first as 8N1 or 8N2.
// Bit timing comes from the shared external baud tick generator, which this
// block enables through baud_en for as long as frames are being sent.
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low; abandons any frame in flight
//   tx_data    byte to send, sampled when tx_wr=1
//   tx_wr      one-cycle write strobe per byte
//   tx_full    FIFO full; writes made while high are dropped
//   baud_tick  one-cycle pulse per bit period from the baud generator
//   baud_en    enables the baud generator while frames are being sent
//   txd        serial line, idles high
//   tx_busy    high while the FSM is not idle
//   tx_done    one-cycle pulse when the last stop bit of a frame ends
module bt_txd
    import bt_txd_pkg::*;
#(
    parameter int DATA_BITS = BT_DATA_BITS,
    parameter int STOP_BITS = 1,
    parameter int FIFO_AW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_wr,
    output logic                 tx_full,
    input  logic                 baud_tick,
    output logic                 baud_en,
    output logic                 txd,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [CW-1:0]        bit_cnt;
    logic [CW-1:0]        bit_cnt_next;
    logic                 stop_cnt;
    logic                 stop_cnt_next;
    logic                 txd_next;
    logic                 baud_en_next;
    logic                 tx_done_next;

    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_rdata;
    logic                 fifo_empty;
    logic [FIFO_AW:0]     fifo_count;

    bt_tx_fifo #(
        .WIDTH (DATA_BITS),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_wr),
        .wdata (tx_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (tx_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // The FIFO's empty flag and count must always agree; the FSM relies on
    // empty to decide whether a pop is legal.
    a_fifo_empty_consistent : assert property (
        @(posedge clk) disable iff (!rst) fifo_empty == (fifo_count == '0)
    );

    // Next-state logic. Every output is registered, so this block computes
    // the value each output register takes on the coming edge.
    always_comb begin
        state_next    = state;
        shift_next    = shift_reg;
        bit_cnt_next  = bit_cnt;
        stop_cnt_next = stop_cnt;
        txd_next      = txd;
        baud_en_next  = baud_en;
        tx_done_next  = 1'b0;
        fifo_pop      = 1'b0;

        case (state)
            TX_IDLE: begin
                // baud_tick is ignored here; the generator is off anyway.
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    shift_next   = fifo_rdata;
                    txd_next     = 1'b0;
                    baud_en_next = 1'b1;
                    state_next   = TX_START;
                end
            end
            TX_START: begin
                if (baud_tick) begin
                    txd_next     = shift_reg[0];
                    bit_cnt_next = '0;
                    state_next   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        txd_next      = 1'b1;
                        stop_cnt_next = 1'b0;
                        state_next    = TX_STOP;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        txd_next     = shift_reg[1];
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == LAST_STOP) begin
                        tx_done_next = 1'b1;
                        // Chaining straight into the next start bit keeps
                        // baud_en high so frames follow with no idle gap.
                        if (!fifo_empty) begin
                            fifo_pop   = 1'b1;
                            shift_next = fifo_rdata;
                            txd_next   = 1'b0;
                            state_next = TX_START;
                        end else begin
                            baud_en_next = 1'b0;
                            state_next   = TX_IDLE;
                        end
                    end else begin
                        stop_cnt_next = stop_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = TX_IDLE;
            end
        endcase
    end

    // State and output registers. tx_busy follows the state being entered
    // so it rises with IDLE->START and falls with STOP->IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= TX_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            txd       <= 1'b1;
            baud_en   <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            stop_cnt  <= stop_cnt_next;
            txd       <= txd_next;
            baud_en   <= baud_en_next;
            tx_busy   <= (state_next != TX_IDLE);
            tx_done   <= tx_done_next;
        end
    end

endmodule
